// File: rtl/dec_rr_arbiter.sv
// -----------------------------------------------------------------------------
// dec_rr_arbiter
//
// Round-robin arbiter that shares one 2-to-4 decoder (decoder2) among four
// requesters. The registered grant drives the decoder's select pair {I1,I2}
// and enable E. A one-hot copy of the decoder output is provided on gnt.
//
// Optional feature macro: DEC_ARB_TIMEOUT_EN
//   defined   : a grant is revoked after MAX_HOLD consecutive cycles, and
//               expire pulses for the first cycle after the revocation.
//   undefined : no hold counter; a grant lasts until its requester releases;
//               expire is constant 0.
//
// Parameters:
//   MAX_HOLD : maximum consecutive grant cycles (1..15), timeout build only
//   CNT_W    : hold counter width, 2**CNT_W > MAX_HOLD
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   req    in   [3:0] request vector, req[k] held while requester k needs it
//   I1     out  select MSB (granted index bit 1)
//   I2     out  select LSB (granted index bit 0)
//   E      out  decoder enable, high while a grant is active
//   gnt    out  [3:0] one-hot grant, equals decoder2 output for {I1,I2,E}
//   busy   out  high in GRANT or GAP
//   expire out  one-cycle pulse when a grant is revoked by timeout
// -----------------------------------------------------------------------------
module dec_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic       I1,
    output logic       I2,
    output logic       E,
    output logic [3:0] gnt,
    output logic       busy,
    output logic       expire
);

    // Reject illegal configurations at elaboration time.
    if (MAX_HOLD < 1 || MAX_HOLD > 15 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_param
        $error("dec_rr_arbiter: illegal MAX_HOLD/CNT_W combination");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] sel, sel_nxt;     // granted index, drives {I1,I2}
    logic [1:0] last, last_nxt;   // most recently served requester
    logic [1:0] winner;
    logic       e_nxt, busy_nxt, expire_nxt;
    logic [3:0] gnt_nxt;
    logic       hold_done;

    assign I1 = sel[1];
    assign I2 = sel[0];

`ifdef DEC_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt, cnt_nxt;
    assign hold_done = (cnt == CNT_W'(MAX_HOLD - 1));
`else
    assign hold_done = 1'b0;
`endif

    // Rotating priority search starting just after the last served index,
    // so the requester that was served most recently is checked last.
    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a
        // default first; a path that leaves one unassigned infers a latch.
        winner = last;
        for (int i = 4; i >= 1; i--) begin
            if (req[2'(last + 2'(i))]) winner = 2'(last + 2'(i));
        end
    end

    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel;
        last_nxt   = last;
        e_nxt      = E;
        busy_nxt   = busy;
        expire_nxt = 1'b0;
`ifdef DEC_ARB_TIMEOUT_EN
        cnt_nxt    = cnt;
`endif
        case (state)
            IDLE: begin
                e_nxt    = 1'b0;
                busy_nxt = 1'b0;
                if (|req) begin
                    state_nxt = GRANT;
                    sel_nxt   = winner;
                    last_nxt  = winner;
                    e_nxt     = 1'b1;
                    busy_nxt  = 1'b1;
`ifdef DEC_ARB_TIMEOUT_EN
                    cnt_nxt   = '0;
`endif
                end
            end
            GRANT: begin
                // Release takes precedence over timeout, so expire only
                // fires when the holder still wants the decoder.
                if (!req[sel]) begin
                    state_nxt = GAP;
                    e_nxt     = 1'b0;
                end else if (hold_done) begin
                    state_nxt  = GAP;
                    e_nxt      = 1'b0;
                    expire_nxt = 1'b1;
                end else begin
`ifdef DEC_ARB_TIMEOUT_EN
                    if (cnt != {CNT_W{1'b1}}) cnt_nxt = cnt + 1'b1;
`endif
                end
            end
            GAP: begin
                // Select lines hold their value so the decoder inputs stay
                // stable while it is disabled.
                state_nxt = IDLE;
                e_nxt     = 1'b0;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                e_nxt     = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
        gnt_nxt = e_nxt ? (4'b0001 << sel_nxt) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples the pre-edge values, independent of order.
        if (rst) begin
            state  <= IDLE;
            sel    <= 2'b00;
            last   <= 2'd3;
            E      <= 1'b0;
            gnt    <= 4'b0000;
            busy   <= 1'b0;
            expire <= 1'b0;
        end else begin
            state  <= state_nxt;
            sel    <= sel_nxt;
            last   <= last_nxt;
            E      <= e_nxt;
            gnt    <= gnt_nxt;
            busy   <= busy_nxt;
            expire <= expire_nxt;
        end
    end

`ifdef DEC_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt_nxt;
    end
`endif

endmodule

// File: tb/tb_dec_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dec_rr_arbiter
//
// Directed self-checking bench for dec_rr_arbiter: reset, round-robin
// rotation, sparse requests, hold timeout (or unbounded hold when the timeout
// macro is not defined) and reset during an active grant.
// -----------------------------------------------------------------------------
module tb_dec_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       I1, I2, E, busy, expire;
    logic [3:0] gnt;

    int total = 0;
    int bad   = 0;

    dec_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .I1     (I1),
        .I2     (I2),
        .E      (E),
        .gnt    (gnt),
        .busy   (busy),
        .expire (expire)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_grant(input string tag, input int idx);
        check({tag, "_E"},    32'(E),         32'd1);
        check({tag, "_sel"},  32'({I1, I2}),  32'(idx));
        check({tag, "_gnt"},  32'(gnt),       32'(1 << idx));
        check({tag, "_busy"}, 32'(busy),      32'd1);
    endtask

    // Drop req[idx], check the GAP cycle, load next_req, check the IDLE cycle.
    task automatic release_gap(input string tag, input int idx, input logic [3:0] next_req);
        req[idx] = 1'b0;
        step();
        check({tag, "_gap_E"},    32'(E),        32'd0);
        check({tag, "_gap_gnt"},  32'(gnt),      32'd0);
        check({tag, "_gap_busy"}, 32'(busy),     32'd1);
        check({tag, "_gap_sel"},  32'({I1, I2}), 32'(idx));
        req = next_req;
        step();
        check({tag, "_idle_E"},    32'(E),    32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;

        // Reset held for two cycles: everything low.
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_E",      32'(E),        32'd0);
            check("rst_sel",    32'({I1, I2}), 32'd0);
            check("rst_gnt",    32'(gnt),      32'd0);
            check("rst_busy",   32'(busy),     32'd0);
            check("rst_expire", 32'(expire),   32'd0);
        end

        // First grant and rotation 0,1,2,3,0,1 with 3-cycle holds.
        rst = 1'b0;
        req = 4'b1111;
        step();
        for (int g = 0; g < 6; g++) begin
            expect_grant("rr_first", g % 4);
            step();
            expect_grant("rr_hold2", g % 4);
            step();
            expect_grant("rr_hold3", g % 4);
            if (g < 5) begin
                release_gap("rr_rel", g % 4, 4'b1111);
                step();
            end
        end

        // Sparse: after index 1 is served, 0011 must go to index 0.
        release_gap("sparse_rel", 1, 4'b0011);
        step();
        expect_grant("sparse", 0);

        // Move to a lone request on index 2.
        release_gap("to2_rel", 0, 4'b0100);
        step();
        expect_grant("to2", 2);

`ifdef DEC_ARB_TIMEOUT_EN
        // Held continuously: 8 cycles high, then revoked with expire.
        for (int i = 1; i < 8; i++) begin
            step();
            check("to_hold_E",      32'(E),      32'd1);
            check("to_hold_expire", 32'(expire), 32'd0);
        end
        step();
        check("to_rev_E",      32'(E),      32'd0);
        check("to_rev_expire", 32'(expire), 32'd1);
        check("to_rev_busy",   32'(busy),   32'd1);
        step();
        check("to_idle_E",      32'(E),      32'd0);
        check("to_idle_expire", 32'(expire), 32'd0);
        step();
        expect_grant("to_regrant", 2);
        check("to_regrant_expire", 32'(expire), 32'd0);
`else
        // No timeout: the grant persists while the request is held.
        for (int i = 0; i < 55; i++) begin
            step();
            check("nto_hold_E",      32'(E),      32'd1);
            check("nto_hold_expire", 32'(expire), 32'd0);
        end
`endif

        // Get a grant on index 3, then reset mid-grant.
        release_gap("to3_rel", 2, 4'b1000);
        step();
        expect_grant("to3", 3);
        step();
        expect_grant("to3_hold", 3);
        rst = 1'b1;
        step();
        check("midrst_E",      32'(E),        32'd0);
        check("midrst_sel",    32'({I1, I2}), 32'd0);
        check("midrst_gnt",    32'(gnt),      32'd0);
        check("midrst_busy",   32'(busy),     32'd0);
        check("midrst_expire", 32'(expire),   32'd0);
        rst = 1'b0;
        step();
        expect_grant("postrst", 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dec_rr_arbiter.md
# dec_rr_arbiter

Round-robin arbiter that shares one 2-to-4 decoder (`decoder2`) among four requesters. It drives the decoder's select inputs (`I1`, `I2`) and enable (`E`) from a registered grant. It also outputs a one-hot grant vector identical to the decoder's `y3..y0`. The arbiter sits directly in front of `decoder2`, and its outputs connect port-for-port to the decoder's inputs.

## Interface
Parameters:
- `MAX_HOLD`, default 8: maximum consecutive cycles one requester may hold the grant. Used only when the timeout is compiled in. Legal range 1..15.
- `CNT_W`, default 4: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req`, in, 4: request vector; `req[k]` is held high while requester k needs the decoder.
- `I1`, out, 1: select MSB to `decoder2` (granted index bit 1).
- `I2`, out, 1: select LSB to `decoder2` (granted index bit 0).
- `E`, out, 1: decoder enable; high only while a grant is active.
- `gnt`, out, 4: one-hot grant; `gnt = E ? (4'b0001 << {I1,I2}) : 4'b0000`.
- `busy`, out, 1: high in GRANT or GAP.
- `expire`, out, 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- FSM has three states: IDLE, GRANT, GAP. All outputs are registered.
- Reset (`rst`=1 at an edge):
  - state = IDLE; `I1`=0, `I2`=0, `E`=0, `gnt`=0, `busy`=0, `expire`=0.
  - Round-robin pointer `last` = 3; hold counter = 0.
  - Reset overrides every other event, including reset asserted mid-grant. The grant drops on the same edge, with no GAP cycle.
- IDLE:
  - If `req` != 0, select the winner `w`: the first set bit searching `last+1, last+2, ...` mod 4.
  - Load `{I1,I2}` = w, `E`=1, `last` = w, counter = 0, and go to GRANT.
  - If `req` == 0, stay in IDLE.
- GRANT:
  - If `req[{I1,I2}]` = 0, go to GAP and set `E`=0. Requests from other requesters are ignored while a grant is active.
  - Else, if timeout is compiled in and counter == `MAX_HOLD`-1, go to GAP, set `E`=0, and pulse `expire`=1 for exactly that cycle.
  - Otherwise stay in GRANT and increment the counter, saturating at 2^CNT_W-1.
- GAP:
  - Always exactly one cycle, with `E`=0.
  - `I1`/`I2` hold their last values (decoder inputs stay stable while disabled).
  - Go to IDLE.
- Fairness:
  - A requester that has just been served has lowest priority at the next arbitration.
  - A revoked requester that still asserts `req` re-enters arbitration normally. It is still lowest priority.
- Simultaneous events:
  - In IDLE, all four requests asserted: the winner is `(last+1) mod 4`.
  - Release and timeout in the same cycle: treated as a release; `expire` stays 0.

## Timing
- Request to grant:
  - `req` sampled high at edge N in IDLE gives `E`/`gnt` high after edge N (1-cycle latency).
  - If the arbiter is in GAP when the request appears, latency is 2 cycles.
- Release to next grant:
  - `req[w]` low at edge N gives `E`=0 after edge N (GAP).
  - IDLE follows after N+1; the next grant is visible after N+2.
  - Minimum gap between grants is therefore 2 cycles with `E`=0.
- Maximum hold with timeout:
  - `E` stays high for exactly `MAX_HOLD` cycles, then drops.
  - `expire` is high during the first `E`=0 cycle.
- `gnt` always equals what `decoder2` produces for the current `{I1,I2,E}`, in the same cycle.

## Configuration
- Macro: `DEC_ARB_TIMEOUT_EN`.
- Defined: the hold counter and `MAX_HOLD` revocation are active, and `expire` pulses as described.
- Undefined:
  - No counter logic is generated.
  - A grant lasts until its requester drops `req`, however long that takes.
  - `expire` is tied to 0.
  - The port list is unchanged.

## Test plan
- **Reset and first grant:** `rst`=1 for 2 cycles, then `req`=4'b1111. Required: all outputs 0 during reset. One cycle after `req` is sampled, `E`=1, `{I1,I2}`=00, `gnt`=4'b0001.
- **Round-robin rotation:** keep `req`=4'b1111 and release each grant after 3 cycles. Required grant order is 0,1,2,3,0. Each grant is separated by 2 cycles of `E`=0.
- **Sparse requests:** after the grant to index 1 is released, `req`=4'b0011. Required: the next grant goes to 0 (`gnt`=4'b0001), not 1.
- **Timeout (macro defined, `MAX_HOLD`=8):** `req`=4'b0100 held high continuously. Required:
  - `E`=1 for exactly 8 cycles, then `E`=0 with `expire`=1 for 1 cycle.
  - Regrant to index 2 follows 2 cycles after `E` fell.
  - With the macro undefined, `E` stays high for 50+ cycles and `expire` stays 0.
- **Reset mid-grant:** grant active on index 3, then `rst`=1 for one cycle. Required:
  - `E`=0 and `{I1,I2}`=00 immediately after that edge.
  - With `req`=4'b1000 still high, the next grant goes to index 3 one cycle after reset is released.
